// File: rtl/eth_rx_tile_pkg.sv
// Shared types for the Ethernet RX tile: FSM states, NoC header flit, lookup-table entry.
// The MAC header is {dst_mac, src_mac, eth_type}, so the EtherType sits in the low 16 bits.
package eth_rx_tile_pkg;
  localparam int ETH_HDR_W   = 112;
  localparam int MTU_SIZE_W  = 16;
  localparam int ETH_TYPE_W  = 16;
  localparam int XY_WIDTH    = 8;
  localparam int MSG_LEN_W   = 8;
  localparam int PKT_NUM_W   = 16;
  localparam int TBL_CHAN_W  = 8;

  typedef enum logic [2:0] {IDLE, LOOKUP, HDR, DATA, DRAIN} rx_state_e;

  typedef struct packed {
    logic [XY_WIDTH-1:0]   dst_x;
    logic [XY_WIDTH-1:0]   dst_y;
    logic [XY_WIDTH-1:0]   src_x;
    logic [XY_WIDTH-1:0]   src_y;
    logic [MSG_LEN_W-1:0]  msg_len;
    logic [PKT_NUM_W-1:0]  pkt_num;
    logic [ETH_TYPE_W-1:0] eth_type;
  } hdr_flit_t;

  typedef struct packed {
    logic                  valid;
    logic [ETH_TYPE_W-1:0] tag;
    logic [XY_WIDTH-1:0]   dst_x;
    logic [XY_WIDTH-1:0]   dst_y;
    logic [TBL_CHAN_W-1:0] chan;
  } tbl_entry_t;

  // One header flit plus the payload beats; the extra bit keeps size+bytes-1 from overflowing.
  function automatic logic [MSG_LEN_W-1:0] calc_msg_len(input logic [MTU_SIZE_W-1:0] size,
                                                        input int bytes_per_flit);
    logic [MTU_SIZE_W:0] beats;
    beats = ({1'b0, size} + (MTU_SIZE_W+1)'(bytes_per_flit - 1)) / (MTU_SIZE_W+1)'(bytes_per_flit);
    return MSG_LEN_W'(beats + (MTU_SIZE_W+1)'(1));
  endfunction
endpackage

// File: rtl/eth_rx_out_tbl.sv
// EtherType routing table: flop array with a write port and a one-cycle registered match.
// Lowest matching index wins; a same-cycle write is only visible to later lookups.
module eth_rx_out_tbl
  import eth_rx_tile_pkg::*;
#(
  parameter int TBL_DEPTH = 8,
  parameter int IDX_W     = 3,
  parameter int CHAN_W    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_val,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [ETH_TYPE_W-1:0] wr_tag,
  input  logic [XY_WIDTH-1:0]   wr_dst_x,
  input  logic [XY_WIDTH-1:0]   wr_dst_y,
  input  logic [CHAN_W-1:0]     wr_chan,
  input  logic                  wr_en,
  input  logic                  lookup_en,
  input  logic [ETH_TYPE_W-1:0] lookup_tag,
  output logic                  match_any,
  output logic                  hit,
  output logic [XY_WIDTH-1:0]   dst_x,
  output logic [XY_WIDTH-1:0]   dst_y,
  output logic [CHAN_W-1:0]     chan
);
  tbl_entry_t           tbl_reg [TBL_DEPTH];
  logic [TBL_DEPTH-1:0] match_vec;
  tbl_entry_t           sel_entry;

  genvar gi;
  generate
    for (gi = 0; gi < TBL_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst) begin
          tbl_reg[gi] <= '0;
        end else if (wr_val && wr_idx == IDX_W'(gi)) begin
          tbl_reg[gi] <= '{valid: wr_en, tag: wr_tag, dst_x: wr_dst_x, dst_y: wr_dst_y,
                           chan: TBL_CHAN_W'(wr_chan)};
        end
      end
      assign match_vec[gi] = tbl_reg[gi].valid && (tbl_reg[gi].tag == lookup_tag);
    end
  endgenerate

  always_comb begin
    sel_entry = '0;
    for (int i = TBL_DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) sel_entry = tbl_reg[i];
    end
  end

  assign match_any = |match_vec;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hit   <= 1'b0;
      dst_x <= '0;
      dst_y <= '0;
      chan  <= '0;
    end else if (lookup_en) begin
      hit   <= match_any;
      dst_x <= sel_entry.dst_x;
      dst_y <= sel_entry.dst_y;
      chan  <= CHAN_W'(sel_entry.chan);
    end
  end
endmodule

// File: rtl/eth_rx_noc_out_multi.sv
// Ethernet RX to multi-channel NoC: EtherType lookup picks channel/destination, then header + payload.
// ETH_RX_OUT_MISS_DROP_EN: defined drains unmatched frames; undefined sends them to channel 0, home tile.
module eth_rx_noc_out_multi
  import eth_rx_tile_pkg::*;
#(
  parameter int SRC_X     = -1,
  parameter int SRC_Y     = -1,
  parameter int NUM_CHAN  = 2,
  parameter int TBL_DEPTH = 8,
  parameter int DATA_W    = 512
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          eth_format_eth_rx_out_hdr_val,
  input  logic [ETH_HDR_W-1:0]                          eth_format_eth_rx_out_eth_hdr,
  input  logic [MTU_SIZE_W-1:0]                         eth_format_eth_rx_out_data_size,
  output logic                                          eth_rx_out_eth_format_hdr_rdy,
  input  logic                                          eth_format_eth_rx_out_data_val,
  input  logic [DATA_W-1:0]                             eth_format_eth_rx_out_data,
  input  logic                                          eth_format_eth_rx_out_data_last,
  input  logic [$clog2(DATA_W/8)-1:0]                   eth_format_eth_rx_out_data_padbytes,
  output logic                                          eth_rx_out_eth_format_data_rdy,
  output logic [NUM_CHAN-1:0]                           eth_rx_out_noc_vrtoc_val,
  output logic [NUM_CHAN*DATA_W-1:0]                    eth_rx_out_noc_vrtoc_data,
  input  logic [NUM_CHAN-1:0]                           noc_vrtoc_eth_rx_out_rdy,
  input  logic                                          tbl_wr_val,
  input  logic [(TBL_DEPTH > 1 ? $clog2(TBL_DEPTH) : 1)-1:0] tbl_wr_idx,
  input  logic [ETH_TYPE_W-1:0]                         tbl_wr_tag,
  input  logic [XY_WIDTH-1:0]                           tbl_wr_dst_x,
  input  logic [XY_WIDTH-1:0]                           tbl_wr_dst_y,
  input  logic [(NUM_CHAN > 1 ? $clog2(NUM_CHAN) : 1)-1:0]   tbl_wr_chan,
  input  logic                                          tbl_wr_en,
  output logic [NUM_CHAN*32-1:0]                        pkt_cnt,
  output logic [31:0]                                   miss_cnt
);
  localparam int CHAN_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int IDX_W  = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;

  rx_state_e             state_reg;
  logic [ETH_TYPE_W-1:0] eth_type_reg;
  logic [MTU_SIZE_W-1:0] size_reg;
  logic [31:0]           miss_cnt_reg;
  logic [31:0]           pkt_cnt_reg [NUM_CHAN];
  logic [PKT_NUM_W-1:0]  pkt_num_reg [NUM_CHAN];

  logic                  match_any, tbl_hit;
  logic [XY_WIDTH-1:0]   tbl_dst_x, tbl_dst_y, sel_dst_x, sel_dst_y;
  logic [CHAN_W-1:0]     tbl_chan, sel_chan;
  logic                  sel_rdy, beat_hs;
  hdr_flit_t             hdr_flit;
  logic [DATA_W-1:0]     flit_data;
  logic                  unused_ok;

  eth_rx_out_tbl #(.TBL_DEPTH(TBL_DEPTH), .IDX_W(IDX_W), .CHAN_W(CHAN_W)) u_tbl (
    .clk       (clk),
    .rst       (rst),
    .wr_val    (tbl_wr_val),
    .wr_idx    (tbl_wr_idx),
    .wr_tag    (tbl_wr_tag),
    .wr_dst_x  (tbl_wr_dst_x),
    .wr_dst_y  (tbl_wr_dst_y),
    .wr_chan   (tbl_wr_chan),
    .wr_en     (tbl_wr_en),
    .lookup_en (state_reg == LOOKUP),
    .lookup_tag(eth_type_reg),
    .match_any (match_any),
    .hit       (tbl_hit),
    .dst_x     (tbl_dst_x),
    .dst_y     (tbl_dst_y),
    .chan      (tbl_chan)
  );

  // A registered miss routes back to this tile on channel 0 (only reachable when misses forward).
  assign sel_chan  = tbl_hit ? tbl_chan  : '0;
  assign sel_dst_x = tbl_hit ? tbl_dst_x : XY_WIDTH'(SRC_X);
  assign sel_dst_y = tbl_hit ? tbl_dst_y : XY_WIDTH'(SRC_Y);
  assign sel_rdy   = noc_vrtoc_eth_rx_out_rdy[sel_chan];
  assign beat_hs   = eth_format_eth_rx_out_data_val && sel_rdy;

  always_comb begin
    hdr_flit          = '0;
    hdr_flit.dst_x    = sel_dst_x;
    hdr_flit.dst_y    = sel_dst_y;
    hdr_flit.src_x    = XY_WIDTH'(SRC_X);
    hdr_flit.src_y    = XY_WIDTH'(SRC_Y);
    hdr_flit.msg_len  = calc_msg_len(size_reg, DATA_W / 8);
    hdr_flit.pkt_num  = pkt_num_reg[sel_chan];
    hdr_flit.eth_type = eth_type_reg;
  end

  assign flit_data = (state_reg == HDR) ? DATA_W'(hdr_flit) : eth_format_eth_rx_out_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      eth_type_reg <= '0;
      size_reg     <= '0;
      miss_cnt_reg <= '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
        pkt_cnt_reg[i] <= '0;
        pkt_num_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: if (eth_format_eth_rx_out_hdr_val) begin
          eth_type_reg <= eth_format_eth_rx_out_eth_hdr[ETH_TYPE_W-1:0];
          size_reg     <= eth_format_eth_rx_out_data_size;
          state_reg    <= LOOKUP;
        end
        LOOKUP: if (match_any) begin
          state_reg <= HDR;
        end else begin
          miss_cnt_reg <= miss_cnt_reg + 32'd1;
`ifdef ETH_RX_OUT_MISS_DROP_EN
          state_reg <= DRAIN;
`else
          state_reg <= HDR;
`endif
        end
        HDR: if (sel_rdy) begin
          pkt_num_reg[sel_chan] <= pkt_num_reg[sel_chan] + PKT_NUM_W'(1);
          state_reg             <= DATA;
        end
        DATA: if (beat_hs && eth_format_eth_rx_out_data_last) begin
          pkt_cnt_reg[sel_chan] <= pkt_cnt_reg[sel_chan] + 32'd1;
          state_reg             <= IDLE;
        end
        DRAIN: if (eth_format_eth_rx_out_data_val && eth_format_eth_rx_out_data_last) begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign eth_rx_out_eth_format_hdr_rdy  = rst && (state_reg == IDLE);
  assign eth_rx_out_eth_format_data_rdy = rst && (((state_reg == DATA) && sel_rdy) ||
                                                  (state_reg == DRAIN));
  assign miss_cnt = miss_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
      assign eth_rx_out_noc_vrtoc_val[gi] = rst && (sel_chan == CHAN_W'(gi)) &&
          ((state_reg == HDR) || ((state_reg == DATA) && eth_format_eth_rx_out_data_val));
      assign eth_rx_out_noc_vrtoc_data[gi*DATA_W +: DATA_W] = flit_data;
      assign pkt_cnt[gi*32 +: 32] = pkt_cnt_reg[gi];
    end
  endgenerate

  // Padding is implied by data_size and MAC addresses are not routed on.
  assign unused_ok = ^{eth_format_eth_rx_out_data_padbytes,
                       eth_format_eth_rx_out_eth_hdr[ETH_HDR_W-1:ETH_TYPE_W]};
endmodule

// File: tb/tb_eth_rx_noc_out_multi.sv
// Directed bench for eth_rx_noc_out_multi (SRC=(5,6), 2 channels, 512-bit flits); honours ETH_RX_OUT_MISS_DROP_EN.
module tb_eth_rx_noc_out_multi;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          hdr_val = 0, hdr_rdy, data_val = 0, data_last = 0, data_rdy;
  logic [111:0]  eth_hdr = '0;
  logic [15:0]   data_size = '0;
  logic [511:0]  data = '0;
  logic [5:0]    padbytes = '0;
  logic [1:0]    vrtoc_val, noc_rdy = 2'b11;
  logic [1023:0] vrtoc_data;
  logic          wr_val = 0, wr_en = 0;
  logic [2:0]    wr_idx = '0;
  logic [15:0]   wr_tag = '0;
  logic [7:0]    wr_x = '0, wr_y = '0;
  logic [0:0]    wr_chan = '0;
  logic [63:0]   pkt_cnt;
  logic [31:0]   miss_cnt;

  eth_rx_noc_out_multi #(.SRC_X(5), .SRC_Y(6), .NUM_CHAN(2), .TBL_DEPTH(8), .DATA_W(512)) dut (
    .clk(clk), .rst(rst),
    .eth_format_eth_rx_out_hdr_val(hdr_val), .eth_format_eth_rx_out_eth_hdr(eth_hdr),
    .eth_format_eth_rx_out_data_size(data_size), .eth_rx_out_eth_format_hdr_rdy(hdr_rdy),
    .eth_format_eth_rx_out_data_val(data_val), .eth_format_eth_rx_out_data(data),
    .eth_format_eth_rx_out_data_last(data_last), .eth_format_eth_rx_out_data_padbytes(padbytes),
    .eth_rx_out_eth_format_data_rdy(data_rdy),
    .eth_rx_out_noc_vrtoc_val(vrtoc_val), .eth_rx_out_noc_vrtoc_data(vrtoc_data),
    .noc_vrtoc_eth_rx_out_rdy(noc_rdy),
    .tbl_wr_val(wr_val), .tbl_wr_idx(wr_idx), .tbl_wr_tag(wr_tag), .tbl_wr_dst_x(wr_x),
    .tbl_wr_dst_y(wr_y), .tbl_wr_chan(wr_chan), .tbl_wr_en(wr_en),
    .pkt_cnt(pkt_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0, failures = 0;
  int drv_timeouts = 0, drv_stall_low = 0;
  logic [1:0] rst_val_obs;

  // Monitor: every NoC handshake, valid cycles per channel, consumed MAC beats.
  logic [511:0] mon_data[$];
  int           mon_chan[$];
  int           val_seen[2] = '{0, 0};
  int           mon_beats = 0;
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (vrtoc_val[c]) val_seen[c]++;
      if (vrtoc_val[c] && noc_rdy[c]) begin
        mon_data.push_back(vrtoc_data[c*512 +: 512]);
        mon_chan.push_back(c);
      end
    end
    if (data_val && data_rdy) mon_beats++;
  end

  function automatic logic [511:0] hdr_flit(input logic [7:0] dx, input logic [7:0] dy,
                                            input logic [7:0] mlen, input logic [15:0] pnum,
                                            input logic [15:0] etype);
    logic [71:0] h;
    h = {dx, dy, 8'd5, 8'd6, mlen, pnum, etype};
    return {440'd0, h};
  endfunction

  function automatic logic [511:0] beat_data(input logic [15:0] etype, input int b);
    return {8{16'hA5A5, etype, 32'(b)}};
  endfunction

  task automatic tbl_write(input int idx, input logic [15:0] tag, input logic [7:0] x,
                           input logic [7:0] y, input int ch, input logic en);
    wr_val = 1; wr_idx = 3'(idx); wr_tag = tag; wr_x = x; wr_y = y; wr_chan = 1'(ch); wr_en = en;
    @(posedge clk); #1;
    wr_val = 0;
  endtask

  task automatic send_pkt(input logic [15:0] etype, input logic [15:0] size, input int nbeats,
                          input int stall_beat, input int stall_len, input logic [1:0] stall_mask,
                          input int rst_beat);
    int n;
    eth_hdr = {48'h0200_0000_0001, 48'h0200_0000_0002, etype};
    data_size = size;
    hdr_val = 1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (hdr_rdy === 1'b1) break;
      n++;
      if (n > 50) begin drv_timeouts++; break; end
    end
    @(posedge clk); #1;
    hdr_val = 0;
    for (int b = 0; b < nbeats; b++) begin
      data = beat_data(etype, b);
      data_val = 1;
      data_last = (b == nbeats - 1);
      if (b == rst_beat) begin
        rst = 0;
        @(negedge clk);
        rst_val_obs = vrtoc_val;
        @(posedge clk); #1;
        rst = 1; data_val = 0; data_last = 0;
        return;
      end
      if (b == stall_beat) begin
        noc_rdy = stall_mask;
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          if (data_rdy === 1'b0) drv_stall_low++;
          @(posedge clk); #1;
        end
        noc_rdy = 2'b11;
      end
      n = 0;
      while (1) begin
        @(negedge clk);
        if (data_rdy === 1'b1) break;
        n++;
        if (n > 50) begin drv_timeouts++; break; end
      end
      @(posedge clk); #1;
    end
    data_val = 0; data_last = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (hdr_rdy !== 1'b0) begin failures++; $display("FAIL reset_hdr_rdy got=%b exp=0", hdr_rdy); end
    checks++; if (data_rdy !== 1'b0) begin failures++; $display("FAIL reset_data_rdy got=%b exp=0", data_rdy); end
    checks++; if (vrtoc_val !== 2'b00) begin failures++; $display("FAIL reset_val got=%b exp=00", vrtoc_val); end
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    checks++; if (hdr_rdy !== 1'b1) begin failures++; $display("FAIL idle_hdr_rdy got=%b exp=1", hdr_rdy); end
    checks++; if (pkt_cnt !== 64'd0) begin failures++; $display("FAIL reset_pkt_cnt got=%h exp=0", pkt_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin failures++; $display("FAIL reset_miss_cnt got=%h exp=0", miss_cnt); end
  endtask

  task automatic test_ipv4;
    logic [511:0] exp[$];
    int base, v0;
    tbl_write(0, 16'h0800, 8'd2, 8'd3, 1, 1'b1);
    base = mon_data.size(); v0 = val_seen[0];
    send_pkt(16'h0800, 16'd128, 2, -1, 0, 2'b11, -1);
    exp = '{hdr_flit(8'd2, 8'd3, 8'd3, 16'd0, 16'h0800), beat_data(16'h0800, 0), beat_data(16'h0800, 1)};
    checks++;
    if (mon_data.size() - base !== 3) begin
      failures++; $display("FAIL ipv4_flit_count got=%0d exp=3", mon_data.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (mon_data[base+k] !== exp[k] || mon_chan[base+k] !== 1) begin
          failures++; $display("FAIL ipv4_flit%0d chan=%0d got=%h exp=%h on chan 1", k, mon_chan[base+k], mon_data[base+k][127:0], exp[k][127:0]);
        end
      end
    end
    checks++; if (pkt_cnt[63:32] !== 32'd1) begin failures++; $display("FAIL ipv4_pkt_cnt1 got=%0d exp=1", pkt_cnt[63:32]); end
    checks++; if (pkt_cnt[31:0] !== 32'd0) begin failures++; $display("FAIL ipv4_pkt_cnt0 got=%0d exp=0", pkt_cnt[31:0]); end
    checks++; if (val_seen[0] - v0 !== 0) begin failures++; $display("FAIL ipv4_chan0_idle got=%0d valid cycles exp=0", val_seen[0] - v0); end
  endtask

  task automatic test_priority;
    logic [511:0] exp[$];
    int base;
    tbl_write(4, 16'h0806, 8'd9, 8'd10, 1, 1'b1);
    tbl_write(1, 16'h0806, 8'd7, 8'd8, 0, 1'b1);
    base = mon_data.size();
    send_pkt(16'h0806, 16'd64, 1, -1, 0, 2'b11, -1);
    exp = '{hdr_flit(8'd7, 8'd8, 8'd2, 16'd0, 16'h0806), beat_data(16'h0806, 0)};
    checks++;
    if (mon_data.size() - base !== 2) begin
      failures++; $display("FAIL prio_flit_count got=%0d exp=2", mon_data.size() - base);
    end else begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (mon_data[base+k] !== exp[k] || mon_chan[base+k] !== 0) begin
          failures++; $display("FAIL prio_flit%0d chan=%0d got=%h exp=%h on chan 0", k, mon_chan[base+k], mon_data[base+k][127:0], exp[k][127:0]);
        end
      end
    end
    checks++; if (pkt_cnt[31:0] !== 32'd1) begin failures++; $display("FAIL prio_pkt_cnt0 got=%0d exp=1", pkt_cnt[31:0]); end
  endtask

  task automatic test_miss;
    int base, beats0, v0, v1;
    base = mon_data.size(); beats0 = mon_beats; v0 = val_seen[0]; v1 = val_seen[1];
    send_pkt(16'h88B5, 16'd150, 3, -1, 0, 2'b11, -1);
    checks++; if (miss_cnt !== 32'd1) begin failures++; $display("FAIL miss_cnt got=%0d exp=1", miss_cnt); end
    checks++; if (mon_beats - beats0 !== 3) begin failures++; $display("FAIL miss_beats_consumed got=%0d exp=3", mon_beats - beats0); end
`ifdef ETH_RX_OUT_MISS_DROP_EN
    checks++; if (val_seen[0] - v0 + val_seen[1] - v1 !== 0) begin failures++; $display("FAIL miss_drop_noc_val got=%0d valid cycles exp=0", val_seen[0] - v0 + val_seen[1] - v1); end
    checks++; if (pkt_cnt[31:0] !== 32'd1) begin failures++; $display("FAIL miss_drop_pkt_cnt0 got=%0d exp=1", pkt_cnt[31:0]); end
`else
    checks++; if (val_seen[1] - v1 !== 0) begin failures++; $display("FAIL miss_fwd_chan1_idle got=%0d exp=0", val_seen[1] - v1); end
    checks++;
    if (mon_data.size() - base !== 4) begin
      failures++; $display("FAIL miss_fwd_flit_count got=%0d exp=4", mon_data.size() - base);
    end else begin
      checks++;
      if (mon_data[base] !== hdr_flit(8'd5, 8'd6, 8'd4, 16'd1, 16'h88B5) || mon_chan[base] !== 0) begin
        failures++; $display("FAIL miss_fwd_hdr chan=%0d got=%h exp=%h on chan 0", mon_chan[base], mon_data[base][127:0], hdr_flit(8'd5, 8'd6, 8'd4, 16'd1, 16'h88B5));
      end
      checks++;
      if (mon_data[base+3] !== beat_data(16'h88B5, 2)) begin
        failures++; $display("FAIL miss_fwd_last_beat got=%h exp=%h", mon_data[base+3][127:0], beat_data(16'h88B5, 2));
      end
    end
    checks++; if (pkt_cnt[31:0] !== 32'd2) begin failures++; $display("FAIL miss_fwd_pkt_cnt0 got=%0d exp=2", pkt_cnt[31:0]); end
`endif
  endtask

  task automatic test_stall;
    logic [511:0] exp[$];
    int base, s0;
    base = mon_data.size(); s0 = drv_stall_low;
    send_pkt(16'h0800, 16'd128, 2, 1, 5, 2'b01, -1);
    exp = '{hdr_flit(8'd2, 8'd3, 8'd3, 16'd1, 16'h0800), beat_data(16'h0800, 0), beat_data(16'h0800, 1)};
    checks++; if (drv_stall_low - s0 !== 5) begin failures++; $display("FAIL stall_data_rdy_low got=%0d cycles exp=5", drv_stall_low - s0); end
    checks++;
    if (mon_data.size() - base !== 3) begin
      failures++; $display("FAIL stall_flit_count got=%0d exp=3", mon_data.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (mon_data[base+k] !== exp[k] || mon_chan[base+k] !== 1) begin
          failures++; $display("FAIL stall_flit%0d chan=%0d got=%h exp=%h", k, mon_chan[base+k], mon_data[base+k][127:0], exp[k][127:0]);
        end
      end
    end
    checks++; if (pkt_cnt[63:32] !== 32'd2) begin failures++; $display("FAIL stall_pkt_cnt1 got=%0d exp=2", pkt_cnt[63:32]); end
  endtask

  task automatic test_msg_len;
    int base;
    base = mon_data.size();
    send_pkt(16'h0800, 16'd129, 3, -1, 0, 2'b11, -1);
    send_pkt(16'h0800, 16'd1, 1, -1, 0, 2'b11, -1);
    checks++;
    if (mon_data.size() - base !== 6) begin
      failures++; $display("FAIL msglen_flit_count got=%0d exp=6", mon_data.size() - base);
    end else begin
      checks++;
      if (mon_data[base] !== hdr_flit(8'd2, 8'd3, 8'd4, 16'd2, 16'h0800)) begin
        failures++; $display("FAIL msglen_129 got=%h exp=%h", mon_data[base][127:0], hdr_flit(8'd2, 8'd3, 8'd4, 16'd2, 16'h0800));
      end
      checks++;
      if (mon_data[base+4] !== hdr_flit(8'd2, 8'd3, 8'd2, 16'd3, 16'h0800)) begin
        failures++; $display("FAIL msglen_1 got=%h exp=%h", mon_data[base+4][127:0], hdr_flit(8'd2, 8'd3, 8'd2, 16'd3, 16'h0800));
      end
    end
    checks++; if (pkt_cnt[63:32] !== 32'd4) begin failures++; $display("FAIL msglen_pkt_cnt1 got=%0d exp=4", pkt_cnt[63:32]); end
  endtask

  task automatic test_reset_mid;
    logic [511:0] exp[$];
    int base;
    base = mon_data.size();
    send_pkt(16'h0800, 16'd256, 4, -1, 0, 2'b11, 1);
    checks++; if (rst_val_obs !== 2'b00) begin failures++; $display("FAIL rstmid_val got=%b exp=00", rst_val_obs); end
    repeat (2) @(negedge clk);
    checks++; if (mon_data.size() - base !== 2) begin failures++; $display("FAIL rstmid_flits got=%0d exp=2", mon_data.size() - base); end
    checks++; if (pkt_cnt !== 64'd0) begin failures++; $display("FAIL rstmid_pkt_cnt got=%h exp=0", pkt_cnt); end
    checks++; if (miss_cnt !== 32'd0) begin failures++; $display("FAIL rstmid_miss_cnt got=%0d exp=0", miss_cnt); end
    @(posedge clk); #1;
    tbl_write(0, 16'h0800, 8'd2, 8'd3, 1, 1'b1);
    base = mon_data.size();
    send_pkt(16'h0800, 16'd128, 2, -1, 0, 2'b11, -1);
    exp = '{hdr_flit(8'd2, 8'd3, 8'd3, 16'd0, 16'h0800), beat_data(16'h0800, 0), beat_data(16'h0800, 1)};
    checks++;
    if (mon_data.size() - base !== 3) begin
      failures++; $display("FAIL rstmid_next_count got=%0d exp=3", mon_data.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (mon_data[base+k] !== exp[k] || mon_chan[base+k] !== 1) begin
          failures++; $display("FAIL rstmid_next_flit%0d chan=%0d got=%h exp=%h", k, mon_chan[base+k], mon_data[base+k][127:0], exp[k][127:0]);
        end
      end
    end
    checks++; if (pkt_cnt[63:32] !== 32'd1) begin failures++; $display("FAIL rstmid_next_pkt_cnt1 got=%0d exp=1", pkt_cnt[63:32]); end
  endtask

  initial begin
    test_reset();
    test_ipv4();
    test_priority();
    test_miss();
    test_stall();
    test_msg_len();
    test_reset_mid();
    checks++;
    if (drv_timeouts !== 0) begin failures++; $display("FAIL handshake_timeouts got=%0d exp=0", drv_timeouts); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eth_rx_noc_out_multi.md
ETH_RX_NOC_OUT_MULTI -- requirements
Module: eth_rx_noc_out_multi

Interface
REQ-001 Parameters SHALL be (name, default, meaning): SRC_X, -1, tile X coord; SRC_Y, -1, tile Y coord; NUM_CHAN, 2, NoC output channels; TBL_DEPTH, 8, EtherType table entries; DATA_W, 512, MAC and NoC flit width in bits.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, sole clock; rst, in, 1, synchronous active-low reset.
REQ-003 eth_format_eth_rx_out_hdr_val in 1 / eth_format_eth_rx_out_eth_hdr in ETH_HDR_W / eth_format_eth_rx_out_data_size in MTU_SIZE_W / eth_rx_out_eth_format_hdr_rdy out 1: header handshake.
REQ-004 eth_format_eth_rx_out_data_val in 1 / _data in DATA_W / _data_last in 1 / _data_padbytes in clog2(DATA_W/8) / eth_rx_out_eth_format_data_rdy out 1: payload stream.
REQ-005 eth_rx_out_noc_vrtoc_val out NUM_CHAN / eth_rx_out_noc_vrtoc_data out NUM_CHAN*DATA_W / noc_vrtoc_eth_rx_out_rdy in NUM_CHAN: per-channel NoC outputs.
REQ-006 tbl_wr_val in 1 / tbl_wr_idx in clog2(TBL_DEPTH) / tbl_wr_tag in ETH_TYPE_W / tbl_wr_dst_x, tbl_wr_dst_y in XY_WIDTH / tbl_wr_chan in clog2(NUM_CHAN) / tbl_wr_en in 1: table write, always accepted.
REQ-007 pkt_cnt out NUM_CHAN*32: per-channel forwarded-packet counters; miss_cnt out 32: lookup-miss counter.

Function
REQ-008 FSM states SHALL be IDLE, LOOKUP, HDR, DATA, DRAIN.
REQ-009 IDLE: hdr_rdy=1; on hdr_val register header and data_size, go LOOKUP.
REQ-010 LOOKUP (exactly 1 cycle): parallel match of EtherType against all valid entries; lowest matching index wins; register dst_x, dst_y, chan, hit.
REQ-011 Hit: go HDR; miss: behaviour per REQ-021.
REQ-012 HDR: assert val only on selected chan; flit = dst_x, dst_y, SRC_X, SRC_Y, msg_len, per-channel packet number, EtherType; on rdy go DATA.
REQ-013 msg_len SHALL be 1 + ceil(data_size / (DATA_W/8)), computed at MTU_SIZE_W+1 bits, truncated to MSG_LEN_W.
REQ-014 DATA: combinational passthrough, noc val[chan]=data_val, data_rdy=noc rdy[chan]; no bubble between beats; on last-beat handshake increment pkt_cnt[chan], go IDLE.
REQ-015 Non-selected channels SHALL hold val=0 at all times.
REQ-016 DRAIN: data_rdy=1, no NoC val; on last handshake go IDLE.
REQ-017 Counters SHALL wrap from 2^32-1 to 0.
REQ-018 Table write in same cycle as LOOKUP: lookup uses pre-write contents; write visible next cycle.
REQ-019 Header-only packets do not exist: data stream always has >=1 beat with last set; padbytes not forwarded (receiver derives from data_size).

Reset
REQ-020 While rst=0: FSM to IDLE; all vrtoc_val=0; hdr_rdy=0, data_rdy=0 during reset; all table valid bits, pkt_cnt, miss_cnt, per-channel packet numbers cleared; mid-packet reset abandons the packet with no further flits.

Configuration
REQ-021 Macro ETH_RX_OUT_MISS_DROP_EN: defined -> miss goes DRAIN, payload discarded, miss_cnt increments once per packet; undefined -> miss forwards to chan 0 with dst = (SRC_X, SRC_Y), miss_cnt still increments.

Structure
REQ-022 Package eth_rx_tile_pkg SHALL hold the FSM state enum, header-flit struct, table-entry struct, MSG_LEN_W.
REQ-023 Table SHALL be sub-module eth_rx_out_tbl (flop array, write port, 1-cycle registered match).

Verification
REQ-024 Entry0 tag 0x0800 chan1 dst (2,3); 128-byte IPv4 frame, DATA_W=512 -> chan1 flits: hdr msg_len=3, 2 data beats, pkt_cnt[1]=1, chan0 idle.
REQ-025 noc rdy[1] low 5 cycles in DATA -> data_rdy low those cycles, no beat lost/duplicated.
REQ-026 EtherType 0x88B5 unmatched, macro defined -> 3 beats consumed, no NoC val, miss_cnt=1; undefined -> chan0 hdr dst (SRC_X,SRC_Y).
REQ-027 Entries 1 and 4 both tag 0x0806 -> index 1 destination used.
REQ-028 rst low during 2nd of 4 beats -> val drops next cycle, counters 0, next frame forwarded cleanly.
